matmul_mem_bridge: RTL
======================

# matmul_mem_bridge

Scratchpad memory controller directly downstream of the matrix-multiplication engine. It serves the engine's `mem_operation`/`addr_o`/`data_o`/`mem_opdone` request interface and a host load/unload port. Both ports share one single-port synchronous SRAM macro (OpenRAM style: active-low `csb`/`web`). The host fills the parameter words and operands A and B before `enable`, and reads C back after `done`.

## Interface
Parameters:
- `DATA_W`, default 32: word width; equals `` `TYPE_BW ``.
- `ADDR_W`, default 9: SRAM address width; depth is 2^ADDR_W words.
- `RD_LAT`, default 1: SRAM read latency in cycles after the sampling edge. Legal range is 1..4.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `acc_mem_operation`  in  2  engine request: 00 none, 01 read, 11 write, 10 reserved (treated as none).
- `acc_addr_i`  in  32  engine word address.
- `acc_data_i`  in  DATA_W  engine write data.
- `acc_data_o`  out  DATA_W  read data to the engine.
- `acc_opdone`  out  1  one-cycle completion pulse to the engine.
- `host_req`  in  1  host request, level.
- `host_we`  in  1  1 = write.
- `host_addr`  in  32  host word address.
- `host_wdata`  in  DATA_W  host write data.
- `host_rdata`  out  DATA_W  read data to the host.
- `host_ack`  out  1  one-cycle completion pulse to the host.
- `ram_csb`  out  1  SRAM chip select, active low.
- `ram_web`  out  1  SRAM write enable, active low.
- `ram_addr`  out  ADDR_W  SRAM address.
- `ram_din`  out  DATA_W  SRAM write data.
- `ram_dout`  in  DATA_W  SRAM read data.
- `err_o`  out  1  sticky flag: an out-of-range address was seen.

## Operation
- FSM states: IDLE, WAIT, RESP. An internal owner bit records whether the current access belongs to the engine (ACC) or the host (HOST).
- **IDLE** samples requests.
  - An engine request (01 or 11) has priority over `host_req`.
  - The bridge latches the address, write data and direction of the winning request.
  - It drives the RAM command registers for exactly one cycle.
  - It then moves to WAIT.
- **WAIT**
  - Writes: leave after 1 cycle.
  - Reads: leave after RD_LAT+1 cycles. On the exit edge, `ram_dout` is captured into `acc_data_o` or `host_rdata`.
  - The next state is RESP.
- **RESP**
  - Raises `acc_opdone` or `host_ack` for exactly one cycle.
  - Ignores all inputs; this keeps a still-asserted, stale request from being re-issued.
  - Returns to IDLE.
- **Engine withdrawal:** if `acc_mem_operation` reads 00 during WAIT of an ACC access, the bridge returns to IDLE with no `acc_opdone`.
  - A write is already committed at the RAM edge.
  - A withdrawn read is discarded.
  - A host access is never withdrawn.
- **Out-of-range address** (`addr >= 2^ADDR_W`):
  - No RAM access is made (`ram_csb` stays 1).
  - Reads return 0; writes are dropped.
  - Completion timing equals that of a write.
  - `err_o` is set and stays set until reset.
- Addresses are word addresses. `ram_addr` is the low ADDR_W bits of an in-range address.
- Read data registers hold their value until the next read completes for the same owner.

## Timing
- Reset value of every output is 0, except `ram_csb` = 1 and `ram_web` = 1. The FSM resets to IDLE.
- Let the request first be visible in cycle n:
  - RAM command is driven in cycle n+1.
  - A write (or out-of-range access) gives `opdone`/`ack` high in cycle n+2.
  - A read gives `opdone`/`ack` high in cycle n+2+RD_LAT, with its data valid in that same cycle.
- Minimum gap between IDLE samples is one cycle after RESP. Back-to-back reads take RD_LAT+3 cycles each.
- Engine and host requests in the same cycle: the engine wins, and the host waits with `host_req` held.
- Reset asserted mid-access: asynchronous return to IDLE, `ram_csb` deasserted, no completion pulse. A write whose RAM edge has not yet occurred is lost.

## Structure
- A shared defines header holds:
  - `MEM_OP_NONE` = 2'b00, `MEM_OP_READ` = 2'b01, `MEM_OP_WRITE` = 2'b11.
  - The bridge state encodings.
  - The `` `TYPE_BW `` dependency.
- One sub-module is natural: `mem_bridge_arb`, a combinational fixed-priority grant plus range check.
- The FSM, latency counter and data registers stay in the top module.

## Test plan
- **Reset:** hold `reset_n`=0 -> all outputs at reset values; release with no requests -> `ram_csb` stays 1.
- **Host load, engine read:** host writes 0x0000_0007 to address 4 -> `host_ack` at n+2. Engine reads address 4 (RD_LAT=1) -> `acc_data_o`=7 with `acc_opdone` high in cycle n+3 only.
- **Parameter-fetch pattern:** engine holds 01 while incrementing the address on each `acc_opdone` from 0 to 4, with words preloaded as 2,3,3,2 -> exactly one pulse per address, returned values in order, no duplicate access to the old address.
- **Collision:** engine write 0xDEAD to address 20 and host read of address 20 in the same cycle -> engine completes first, then host reads 0xDEAD.
- **Withdrawal and range:** engine read withdrawn to 00 during WAIT -> no `acc_opdone`. Engine write to address 0x200 (ADDR_W=9) -> `acc_opdone` at n+2, `ram_csb` never low, `err_o`=1 and stays 1.
- **Reset mid-read:** `reset_n` pulsed low during WAIT -> no completion pulse, FSM in IDLE, next request served normally.

Source files
------------

// File: rtl/matmul_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// matmul_mem_bridge_pkg
//   Shared definitions for the matrix-multiply scratchpad bridge:
//   engine memory-operation codes, bridge FSM state encodings, access
//   owner encoding and the engine word width (TYPE_BW).
// ---------------------------------------------------------------------------
package matmul_mem_bridge_pkg;

    // Engine datapath word width; the bridge data width follows it.
    localparam int TYPE_BW = 32;

    // Engine request codes on mem_operation (2'b10 is reserved, means none).
    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_t;

    typedef enum logic {
        OWN_ACC  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // True only for the two real request codes; NONE and reserved are idle.
    function automatic logic is_mem_req(input logic [1:0] op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

endpackage

// File: rtl/matmul_mem_bridge_arb.sv
// ---------------------------------------------------------------------------
// mem_bridge_arb
//   Combinational fixed-priority arbiter between the engine and the host,
//   plus the address range check for the winning request.
//   Ports:
//     acc_mem_operation/acc_addr_i/acc_data_i  engine request
//     host_req/host_we/host_addr/host_wdata    host request
//     gnt_valid     some request is present
//     gnt_owner     winner (engine beats host)
//     gnt_we        winner direction, 1 = write
//     gnt_addr      low ADDR_W bits of the winner address
//     gnt_wdata     winner write data
//     gnt_in_range  winner address lies inside the SRAM
// ---------------------------------------------------------------------------
module mem_bridge_arb
    import matmul_mem_bridge_pkg::*;
#(
    parameter int DATA_W = TYPE_BW,
    parameter int ADDR_W = 9
) (
    input  logic [1:0]        acc_mem_operation,
    input  logic [31:0]       acc_addr_i,
    input  logic [DATA_W-1:0] acc_data_i,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              gnt_valid,
    output owner_t            gnt_owner,
    output logic              gnt_we,
    output logic [ADDR_W-1:0] gnt_addr,
    output logic [DATA_W-1:0] gnt_wdata,
    output logic              gnt_in_range
);

    logic [31:0] sel_addr;

    always_comb begin
        gnt_valid = host_req;
        gnt_owner = OWN_HOST;
        gnt_we    = host_we;
        gnt_wdata = host_wdata;
        sel_addr  = host_addr;
        if (is_mem_req(acc_mem_operation)) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_ACC;
            gnt_we    = (acc_mem_operation == MEM_OP_WRITE);
            gnt_wdata = acc_data_i;
            sel_addr  = acc_addr_i;
        end
    end

    assign gnt_addr     = sel_addr[ADDR_W-1:0];
    assign gnt_in_range = (sel_addr[31:ADDR_W] == '0);

endmodule

// File: rtl/matmul_mem_bridge.sv
// ---------------------------------------------------------------------------
// matmul_mem_bridge
//   Shares one single-port synchronous SRAM (active-low csb/web) between the
//   matrix-multiply engine request interface and a host load/unload port.
//   Each access runs IDLE -> WAIT -> RESP; the engine wins collisions.
//   Ports:
//     clk, reset_n                       clock, async active-low reset
//     acc_mem_operation, acc_addr_i,
//     acc_data_i, acc_data_o, acc_opdone engine request/response
//     host_req, host_we, host_addr,
//     host_wdata, host_rdata, host_ack   host request/response
//     ram_csb, ram_web, ram_addr,
//     ram_din, ram_dout                  SRAM macro port
//     err_o                              sticky out-of-range flag
// ---------------------------------------------------------------------------
module matmul_mem_bridge
    import matmul_mem_bridge_pkg::*;
#(
    parameter int DATA_W = TYPE_BW,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        acc_mem_operation,
    input  logic [31:0]       acc_addr_i,
    input  logic [DATA_W-1:0] acc_data_i,
    output logic [DATA_W-1:0] acc_data_o,
    output logic              acc_opdone,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              ram_csb,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              err_o
);

    localparam int CNT_W = 3;

    bridge_state_t     state_q, state_nxt;
    owner_t            owner_q;
    logic              we_q;
    logic              oor_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              launch;
    logic              finish;

    logic              gnt_valid;
    owner_t            gnt_owner;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              gnt_in_range;

    mem_bridge_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_arb (
        .acc_mem_operation (acc_mem_operation),
        .acc_addr_i        (acc_addr_i),
        .acc_data_i        (acc_data_i),
        .host_req          (host_req),
        .host_we           (host_we),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .gnt_valid         (gnt_valid),
        .gnt_owner         (gnt_owner),
        .gnt_we            (gnt_we),
        .gnt_addr          (gnt_addr),
        .gnt_wdata         (gnt_wdata),
        .gnt_in_range      (gnt_in_range)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // WAIT exits when the latency counter is exhausted; an engine access is
    // abandoned early if the engine drops its request (withdrawal). RESP
    // never looks at inputs so a request still held high is not re-issued.
    always_comb begin
        state_nxt = state_q;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_nxt = ST_WAIT;
                    launch    = 1'b1;
                end
            end
            ST_WAIT: begin
                if ((owner_q == OWN_ACC) && !is_mem_req(acc_mem_operation)) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_nxt = ST_RESP;
                    finish    = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign acc_opdone = (state_q == ST_RESP) && (owner_q == OWN_ACC);
    assign host_ack   = (state_q == ST_RESP) && (owner_q == OWN_HOST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_ACC;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            cnt_q      <= '0;
            ram_csb    <= 1'b1;
            ram_web    <= 1'b1;
            ram_addr   <= '0;
            ram_din    <= '0;
            acc_data_o <= '0;
            host_rdata <= '0;
            err_o      <= 1'b0;
        end else begin
            // SRAM command is a single-cycle strobe.
            ram_csb <= 1'b1;
            ram_web <= 1'b1;
            if (launch) begin
                owner_q <= gnt_owner;
                we_q    <= gnt_we;
                oor_q   <= !gnt_in_range;
                // Writes and out-of-range accesses spend one cycle in WAIT,
                // reads RD_LAT+1 so ram_dout is valid on the exit edge.
                cnt_q   <= (gnt_we || !gnt_in_range) ? '0 : CNT_W'(RD_LAT);
                if (gnt_in_range) begin
                    ram_csb  <= 1'b0;
                    ram_web  <= !gnt_we;
                    ram_addr <= gnt_addr;
                    ram_din  <= gnt_wdata;
                end else begin
                    err_o <= 1'b1;
                end
            end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (finish && !we_q) begin
                if (owner_q == OWN_ACC) begin
                    acc_data_o <= oor_q ? '0 : ram_dout;
                end else begin
                    host_rdata <= oor_q ? '0 : ram_dout;
                end
            end
        end
    end

endmodule
